uart_rx: RTL and testbench

- UART receiver, 8N1, LSB-first. Receive-side counterpart of the debug console transmitter.
- Synchronises the asynchronous serial input and validates the start bit at mid-bit.
- Samples each data and stop bit at bit centre.
- Presents each completed byte through a one-entry valid/ready output register.
- Reports frame errors and overruns as single-cycle pulses for the console/debug path.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, prescaler sizing and
// bit-period arithmetic. Intended to be reused by the transmitter as well.
package uart_pkg;

  localparam int PrescalerCounterWidth = 19;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_t;

  // Number of i_clk cycles spanned by one serial bit.
  function automatic int clocks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input. Both flops
// reset to RESET_VALUE so the synchronised output is defined during reset.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  // NOTE: the reset is synchronous (sampled on the clock edge), so it does not
  // appear in the sensitivity list; state updates use <= so both stages read
  // their pre-edge values and the chain shifts by exactly one stage per clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver. Validates the start bit at mid-bit, samples
// data and stop bits at bit centre, and presents each byte through a
// one-entry valid/ready register with registered frame-error/overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 300000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_uart,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_frame_error,
  output logic                  o_overrun
);

  localparam int Cpb           = clocks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HalfBit       = Cpb / 2;
  localparam int BitCountWidth = $clog2(DATA_WIDTH + 1);

  localparam logic [PrescalerCounterWidth-1:0] CpbReload  = PrescalerCounterWidth'(Cpb - 1);
  localparam logic [PrescalerCounterWidth-1:0] HalfReload = PrescalerCounterWidth'(HalfBit - 1);
  localparam logic [BitCountWidth-1:0]         BitsReload = BitCountWidth'(DATA_WIDTH);

  logic rx_s;

  uart_rx_state_t                   state_q,       state_d;
  logic [PrescalerCounterWidth-1:0] prescaler_q,   prescaler_d;
  logic [BitCountWidth-1:0]         bits_q,        bits_d;
  logic [DATA_WIDTH-1:0]            shift_q,       shift_d;
  logic [DATA_WIDTH-1:0]            data_q,        data_d;
  logic                             valid_q,       valid_d;
  logic                             frame_error_q, frame_error_d;
  logic                             overrun_q,     overrun_d;
  logic                             deliver;

  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_sync_rx (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_uart),
    .o_q   (rx_s)
  );

  // Frame sequencing and output-register next-state logic.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    prescaler_d   = prescaler_q;
    bits_d        = bits_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = valid_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    deliver       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d     = START_BIT;
          prescaler_d = HalfReload;
        end
      end

      START_BIT: begin
        if (prescaler_q == '0) begin
          if (!rx_s) begin
            state_d     = DATA_BITS;
            prescaler_d = CpbReload;
            bits_d      = BitsReload;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          prescaler_d = prescaler_q - 1'b1;
        end
      end

      DATA_BITS: begin
        if (prescaler_q == '0) begin
          shift_d     = {rx_s, shift_q[DATA_WIDTH-1:1]};
          bits_d      = bits_q - 1'b1;
          prescaler_d = CpbReload;
          if (bits_q == BitCountWidth'(1)) begin
            state_d = STOP_BIT;
          end
        end else begin
          prescaler_d = prescaler_q - 1'b1;
        end
      end

      STOP_BIT: begin
        if (prescaler_q == '0) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end else begin
          prescaler_d = prescaler_q - 1'b1;
        end
      end

      WAIT_IDLE: begin
        // Hold off through a break so it reports only one frame error.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // One-entry output register: a delivery may land in the same cycle the
    // consumer drains the previous byte; otherwise a full register drops it.
    if (deliver) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      prescaler_q   <= '0;
      bits_q        <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prescaler_q   <= prescaler_d;
      bits_q        <= bits_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_error = frame_error_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CPB=10. A monitor logs accepted bytes
// and pulses; each scenario compares that log with the bytes a frame-level
// model of the serial line says should arrive.
module tb_uart_rx;

  localparam int Cpb = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       fe;
  logic       ov;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] got_q[$];
  int         fe_cnt;
  int         ov_cnt;
  int         hold_err;
  int         cycle = 0;
  int         last_rise;
  int         start_cycle;
  logic       prev_valid = 1'b0;
  logic       prev_hold  = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH  (8),
    .CLK_FREQ_HZ (1000000),
    .BAUD_RATE   (100000)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_uart        (uart),
    .o_data        (data),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_frame_error (fe),
    .o_overrun     (ov)
  );

  // Monitor: sample 1 time unit after each falling edge, when outputs and
  // i_ready both hold the values the next rising edge will act on.
  always @(negedge clk) begin
    #1;
    cycle++;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (valid && ready) got_q.push_back(data);
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
      if (valid && !prev_valid && last_rise < 0) last_rise = cycle;
      if (prev_hold && data !== prev_data) hold_err++;
      prev_hold  = valid && !ready;
      prev_data  = data;
      prev_valid = valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_obs();
    got_q.delete();
    fe_cnt    = 0;
    ov_cnt    = 0;
    hold_err  = 0;
    last_rise = -1;
  endtask

  task automatic idle(input int n);
    uart = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame; stop_val/stop_cycles shape the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_cycles);
    uart        = 1'b0;
    start_cycle = cycle + 1;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart = b[i];
      repeat (Cpb) @(negedge clk);
    end
    uart = stop_val;
    repeat (stop_cycles) @(negedge clk);
    uart = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    uart  = 1'b1;
    ready = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid); end
    vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", data); end
    vectors++; if (fe !== 1'b0) begin miscompares++; $display("FAIL reset_frame_error: got %b expected 0", fe); end
    vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", ov); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single();
    int lat;
    clear_obs();
    send_frame(8'hA5, 1'b1, Cpb);
    idle(20);
    lat = last_rise - start_cycle;
    vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    vectors++; if (got_q.size() < 1 || got_q[0] !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h expected a5", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    vectors++; if (lat < 97 || lat > 104) begin miscompares++; $display("FAIL single_latency: got %0d expected 97..104", lat); end
    vectors++; if (fe_cnt !== 0 || ov_cnt !== 0) begin miscompares++; $display("FAIL single_pulses: got fe=%0d ov=%0d expected 0/0", fe_cnt, ov_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    exp_q = '{8'h00, 8'hFF, 8'h55};
    clear_obs();
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, Cpb);
    idle(20);
    vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    vectors++; if (fe_cnt !== 0 || ov_cnt !== 0) begin miscompares++; $display("FAIL b2b_pulses: got fe=%0d ov=%0d expected 0/0", fe_cnt, ov_cnt); end
  endtask

  task automatic test_glitch();
    clear_obs();
    uart = 1'b0;
    repeat (3) @(negedge clk);
    idle(20);
    vectors++; if (got_q.size() !== 0 || fe_cnt !== 0 || ov_cnt !== 0) begin miscompares++; $display("FAIL glitch_quiet: got bytes=%0d fe=%0d ov=%0d expected 0/0/0", got_q.size(), fe_cnt, ov_cnt); end
    send_frame(8'h3C, 1'b1, Cpb);
    idle(20);
    vectors++; if (got_q.size() !== 1 || got_q[0] !== 8'h3C) begin miscompares++; $display("FAIL glitch_next: got %0d bytes first %h expected 1 byte 3c", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_frame_error();
    clear_obs();
    send_frame(8'h81, 1'b0, Cpb + 50);
    idle(20);
    vectors++; if (fe_cnt !== 1) begin miscompares++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt); end
    vectors++; if (got_q.size() !== 0 || ov_cnt !== 0) begin miscompares++; $display("FAIL ferr_no_byte: got bytes=%0d ov=%0d expected 0/0", got_q.size(), ov_cnt); end
    clear_obs();
    send_frame(8'h42, 1'b1, Cpb);
    idle(20);
    vectors++; if (got_q.size() !== 1 || got_q[0] !== 8'h42 || fe_cnt !== 0) begin miscompares++; $display("FAIL ferr_recover: got %0d bytes first %h fe=%0d expected 1 byte 42 fe=0", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, fe_cnt); end
  endtask

  task automatic test_overrun();
    clear_obs();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, Cpb);
    send_frame(8'h22, 1'b1, Cpb);
    idle(20);
    vectors++; if (valid !== 1'b1 || data !== 8'h11) begin miscompares++; $display("FAIL ovr_held: got valid=%b data=%h expected 1/11", valid, data); end
    vectors++; if (ov_cnt !== 1 || fe_cnt !== 0) begin miscompares++; $display("FAIL ovr_pulse: got ov=%0d fe=%0d expected 1/0", ov_cnt, fe_cnt); end
    vectors++; if (hold_err !== 0) begin miscompares++; $display("FAIL ovr_stable: got %0d data changes while held expected 0", hold_err); end
    ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ovr_drain_valid: got %b expected 0", valid); end
    vectors++; if (got_q.size() !== 1 || got_q[0] !== 8'h11) begin miscompares++; $display("FAIL ovr_accept: got %0d bytes first %h expected 1 byte 11", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    idle(5);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h99;
    clear_obs();
    uart = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart = b[i];
      repeat (Cpb) @(negedge clk);
    end
    uart = b[4];
    repeat (Cpb / 2) @(negedge clk);
    rst  = 1'b1;
    uart = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (valid !== 1'b0 || data !== 8'h00 || fe !== 1'b0 || ov !== 1'b0) begin miscompares++; $display("FAIL rstmid_outputs: got v=%b d=%h fe=%b ov=%b expected all 0", valid, data, fe, ov); end
    rst = 1'b0;
    idle(30);
    vectors++; if (got_q.size() !== 0 || fe_cnt !== 0 || ov_cnt !== 0) begin miscompares++; $display("FAIL rstmid_quiet: got bytes=%0d fe=%0d ov=%0d expected 0/0/0", got_q.size(), fe_cnt, ov_cnt); end
    clear_obs();
    send_frame(8'h77, 1'b1, Cpb);
    idle(20);
    vectors++; if (got_q.size() !== 1 || got_q[0] !== 8'h77) begin miscompares++; $display("FAIL rstmid_next: got %0d bytes first %h expected 1 byte 77", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  // Random frames with random gaps; roughly one in four carries a bad stop
  // bit. Model: a good frame yields its byte, a bad one yields a frame error.
  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       stop_ok;
    int         exp_fe;
    clear_obs();
    exp_fe = 0;
    for (int n = 0; n < 10; n++) begin
      b       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 3) != 0);
      send_frame(b, stop_ok, Cpb);
      if (stop_ok) begin
        exp_q.push_back(b);
        idle($urandom_range(0, 15));
      end else begin
        exp_fe++;
        idle(Cpb + $urandom_range(0, 15));
      end
    end
    idle(20);
    vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rand_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    vectors++; if (fe_cnt !== exp_fe || ov_cnt !== 0) begin miscompares++; $display("FAIL rand_pulses: got fe=%0d ov=%0d expected %0d/0", fe_cnt, ov_cnt, exp_fe); end
  endtask

  initial begin
    rst   = 1'b1;
    uart  = 1'b1;
    ready = 1'b1;
    clear_obs();
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
